// File: rtl/ram_5x79_queue_ctrl.sv
// Ready/valid FIFO controller wrapped around an external DEPTH x WIDTH two-port RAM.
// Owns the pointers, full/empty tracking, occupancy and flush. The RAM stays outside this block.
module ram_5x79_queue_ctrl #(
  parameter int DEPTH = 5,
  parameter int WIDTH = 79,
  parameter int AW    = 3,
  parameter int FLOW  = 0,
  parameter int PIPE  = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [WIDTH-1:0] enq_bits,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [WIDTH-1:0] deq_bits,
  output logic [AW-1:0]    count,
  output logic [AW-1:0]    R0_addr,
  output logic             R0_en,
  input  logic [WIDTH-1:0] R0_data,
  output logic [AW-1:0]    W0_addr,
  output logic             W0_en,
  output logic [WIDTH-1:0] W0_data
);

  localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTHW = (AW+1)'(DEPTH);
  localparam logic          FLOW_B = (FLOW != 0);
  localparam logic          PIPE_B = (PIPE != 0);

  logic [AW-1:0] enq_ptr, deq_ptr;
  logic          maybe_full;
  logic          ptr_match, empty, full, bypass;
  logic          do_enq, do_deq;
  logic [AW:0]   cnt_w;

  assign ptr_match = (enq_ptr == deq_ptr);
  assign empty     = ptr_match & ~maybe_full;
  assign full      = ptr_match & maybe_full;
  assign bypass    = FLOW_B & empty;

  // Reset forces the idle handshake values even if inputs are toggling.
  assign enq_ready = ~reset_n | (~flush & (~full | (PIPE_B & deq_ready)));
  assign deq_valid = reset_n & ~flush & (~empty | (FLOW_B & enq_valid));

  assign do_enq = reset_n & enq_valid & enq_ready & ~(bypass & deq_ready);
  assign do_deq = deq_ready & deq_valid & ~bypass;

  assign W0_en    = do_enq;
  assign W0_addr  = enq_ptr;
  assign W0_data  = enq_bits;
  assign R0_en    = ~empty;
  assign R0_addr  = deq_ptr;
  assign deq_bits = bypass ? enq_bits : R0_data;

  always_comb begin
    cnt_w = '0;
    if (ptr_match)
      cnt_w = maybe_full ? DEPTHW : '0;
    else if (enq_ptr > deq_ptr)
      cnt_w = {1'b0, enq_ptr} - {1'b0, deq_ptr};
    else
      cnt_w = DEPTHW + {1'b0, enq_ptr} - {1'b0, deq_ptr};
  end
  assign count = cnt_w[AW-1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      enq_ptr    <= '0;
      deq_ptr    <= '0;
      maybe_full <= 1'b0;
    end else if (flush) begin
      enq_ptr    <= '0;
      deq_ptr    <= '0;
      maybe_full <= 1'b0;
    end else begin
      // Non-power-of-two depth: wrap explicitly at the last entry.
      if (do_enq) enq_ptr <= (enq_ptr == LAST) ? '0 : enq_ptr + 1'b1;
      if (do_deq) deq_ptr <= (deq_ptr == LAST) ? '0 : deq_ptr + 1'b1;
      if (do_enq != do_deq) maybe_full <= do_enq;
    end
  end

  always_ff @(posedge clock) begin
    if (reset_n) begin
      assert (enq_ptr <= LAST && deq_ptr <= LAST);
      assert (cnt_w <= DEPTHW);
    end
  end

endmodule

// File: tb/tb_ram_5x79_queue_ctrl.sv
// Bench for ram_5x79_queue_ctrl: a plain-queue model checks two instances (FLOW/PIPE off and on)
// every cycle under shared directed + random stimulus, plus literal checks from the test plan.
module tb_ram_5x79_queue_ctrl;
  localparam int W = 79;
  localparam int D = 5;

  logic         clock = 1'b0;
  logic         reset_n, flush, enq_valid, deq_ready;
  logic [W-1:0] enq_bits;

  logic         er[2], dv[2], r0e[2], w0e[2];
  logic [W-1:0] db[2], r0d[2], w0d[2];
  logic [2:0]   cnt[2], r0a[2], w0a[2];

  logic [W-1:0] mem[2][D];

  int ncmp = 0;
  int nfail = 0;

  always #5 clock = ~clock;

  ram_5x79_queue_ctrl #(.FLOW(0), .PIPE(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(er[0]), .enq_bits(enq_bits),
    .deq_valid(dv[0]), .deq_ready(deq_ready), .deq_bits(db[0]), .count(cnt[0]),
    .R0_addr(r0a[0]), .R0_en(r0e[0]), .R0_data(r0d[0]),
    .W0_addr(w0a[0]), .W0_en(w0e[0]), .W0_data(w0d[0]));

  ram_5x79_queue_ctrl #(.FLOW(1), .PIPE(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(er[1]), .enq_bits(enq_bits),
    .deq_valid(dv[1]), .deq_ready(deq_ready), .deq_bits(db[1]), .count(cnt[1]),
    .R0_addr(r0a[1]), .R0_en(r0e[1]), .R0_data(r0d[1]),
    .W0_addr(w0a[1]), .W0_en(w0e[1]), .W0_data(w0d[1]));

  // RAM macro stand-ins: synchronous write, combinational read.
  initial for (int d = 0; d < 2; d++) for (int i = 0; i < D; i++) mem[d][i] = '0;
  always @(posedge clock)
    for (int d = 0; d < 2; d++)
      if (w0e[d] && w0a[d] < 3'(D)) mem[d][w0a[d]] <= w0d[d];
  assign r0d[0] = (r0a[0] < 3'(D)) ? mem[0][r0a[0]] : '0;
  assign r0d[1] = (r0a[1] < 3'(D)) ? mem[1][r0a[1]] : '0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: occupancy, head slot and stored payload per instance.
  int           msize[2], mhead[2];
  logic [W-1:0] mdat[2][D];
  initial for (int d = 0; d < 2; d++) begin msize[d] = 0; mhead[d] = 0; end

  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      bit fl, pp, emp, ful, e_er, e_dv, byp, e_wen, e_deq;
      int slot;
      fl = (d == 1); pp = (d == 1);
      if (!reset_n) begin
        chk($sformatf("rst_enq_ready%0d", d), W'(er[d]), W'(1));
        chk($sformatf("rst_deq_valid%0d", d), W'(dv[d]), W'(0));
        chk($sformatf("rst_count%0d", d), W'(cnt[d]), W'(0));
        chk($sformatf("rst_w0_en%0d", d), W'(w0e[d]), W'(0));
        chk($sformatf("rst_r0_en%0d", d), W'(r0e[d]), W'(0));
        msize[d] = 0; mhead[d] = 0;
      end else begin
        emp   = (msize[d] == 0);
        ful   = (msize[d] == D);
        e_er  = !flush && (!ful || (pp && deq_ready));
        e_dv  = !flush && (!emp || (fl && enq_valid));
        byp   = fl && emp;
        e_wen = enq_valid && e_er && !(byp && deq_ready);
        e_deq = deq_ready && e_dv && !byp;
        slot  = (mhead[d] + msize[d]) % D;
        chk($sformatf("enq_ready%0d", d), W'(er[d]), W'(e_er));
        chk($sformatf("deq_valid%0d", d), W'(dv[d]), W'(e_dv));
        chk($sformatf("count%0d", d), W'(cnt[d]), W'(msize[d]));
        chk($sformatf("w0_en%0d", d), W'(w0e[d]), W'(e_wen));
        chk($sformatf("r0_en%0d", d), W'(r0e[d]), W'(!emp));
        if (e_wen) begin
          chk($sformatf("w0_addr%0d", d), W'(w0a[d]), W'(slot));
          chk($sformatf("w0_data%0d", d), w0d[d], enq_bits);
        end
        if (!emp) chk($sformatf("r0_addr%0d", d), W'(r0a[d]), W'(mhead[d]));
        if (e_dv) chk($sformatf("deq_bits%0d", d), db[d], emp ? enq_bits : mdat[d][mhead[d]]);
        if (flush) begin
          msize[d] = 0; mhead[d] = 0;
        end else begin
          if (e_deq) begin mhead[d] = (mhead[d] + 1) % D; msize[d]--; end
          if (e_wen) begin mdat[d][slot] = enq_bits; msize[d]++; end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clock); #1;
  endtask

  task automatic drive(input logic ev, input logic [W-1:0] eb, input logic dr, input logic fl);
    enq_valid = ev; enq_bits = eb; deq_ready = dr; flush = fl;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(0, '0, 0, 0);
    #1;
    chk("reset_count", W'(cnt[0]), W'(0));
    chk("reset_enq_ready", W'(er[0]), W'(1));
    #11 reset_n = 1'b1;
    tick();

    // Fill to full, then offer a sixth beat.
    for (int i = 1; i <= D; i++) begin
      drive(1, W'(i), 0, 0);
      tick();
      chk($sformatf("fill_count%0d", i), W'(cnt[0]), W'(i));
    end
    drive(1, W'(6), 0, 0); #1;
    chk("full_enq_ready", W'(er[0]), W'(0));
    chk("full_no_write0", W'(w0e[0]), W'(0));
    chk("full_no_write1", W'(w0e[1]), W'(0));
    tick();

    // Drain in order.
    for (int i = 1; i <= D; i++) begin
      drive(0, '0, 1, 0); #1;
      chk($sformatf("drain_bits%0d", i), db[0], W'(i));
      tick();
    end
    chk("drained_count", W'(cnt[0]), W'(0));
    chk("drained_valid", W'(dv[0]), W'(0));

    // Wrap-around: 3 in, 3 out, then 5 in, 5 out.
    for (int i = 0; i < 3; i++) begin
      drive(1, W'(11 + i), 0, 0); #1;
      chk($sformatf("wrapA_addr%0d", i), W'(w0a[0]), W'(i));
      tick();
    end
    for (int i = 0; i < 3; i++) begin drive(0, '0, 1, 0); tick(); end
    for (int i = 0; i < 5; i++) begin
      int exp_addr;
      exp_addr = (3 + i) % 5;
      drive(1, W'(21 + i), 0, 0); #1;
      chk($sformatf("wrapB_addr%0d", i), W'(w0a[0]), W'(exp_addr));
      tick();
    end
    chk("wrap_full_count", W'(cnt[0]), W'(5));
    for (int i = 0; i < 5; i++) begin
      drive(0, '0, 1, 0); #1;
      chk($sformatf("wrap_bits%0d", i), db[0], W'(21 + i));
      tick();
    end

    // Concurrent enq+deq at count 2.
    drive(1, W'(200), 0, 0); tick();
    drive(1, W'(201), 0, 0); tick();
    for (int i = 0; i < 10; i++) begin
      drive(1, W'(100 + i), 1, 0); #1;
      chk($sformatf("conc_bits%0d", i), db[0], (i < 2) ? W'(200 + i) : W'(100 + i - 2));
      tick();
      chk($sformatf("conc_count%0d", i), W'(cnt[0]), W'(2));
    end
    drive(0, '0, 1, 0); tick(); tick();

    // Flow-through on the FLOW instance while empty.
    drive(1, W'(8'h7A), 1, 0); #1;
    chk("flow_valid", W'(dv[1]), W'(1));
    chk("flow_bits", db[1], W'(8'h7A));
    chk("flow_no_write", W'(w0e[1]), W'(0));
    tick();
    chk("flow_count", W'(cnt[1]), W'(0));
    drive(0, '0, 1, 0); tick();

    // Flush at count 3 with a beat on offer.
    for (int i = 0; i < 3; i++) begin drive(1, W'(40 + i), 0, 0); tick(); end
    drive(1, W'(50), 0, 1); #1;
    chk("flush_enq_ready", W'(er[0]), W'(0));
    tick();
    drive(0, '0, 0, 0); #1;
    chk("flush_count", W'(cnt[0]), W'(0));
    chk("flush_valid", W'(dv[0]), W'(0));
    tick();

    // Random traffic with an asynchronous reset pulse in the middle.
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 9) < 6, {$urandom, $urandom, $urandom}, $urandom_range(0, 1),
            $urandom_range(0, 19) == 0);
      if (c == 300) begin
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_count", W'(cnt[0]), W'(0));
        chk("midrst_valid", W'(dv[0]), W'(0));
        @(posedge clock); #3 reset_n = 1'b1;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
